// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request, response and data-memory signals of the
// load/store unit, bundled so the unit and its environment share one bus.
//
// Handshake rule (request and response channels alike): a transfer happens on
// the rising clk edge where valid && ready are both high. The sender holds
// valid and its payload steady until that edge. The receiver may raise or
// lower ready at will. ready without valid does nothing.
//
// Memory side: mem_read / mem_write are single-cycle strobes. mem_addr and
// mem_wdata are steady from the setup cycle through one cycle after the strobe.
//
// Modports:
//   slave  - the load/store unit (receives requests, drives the memory bus)
//   master - the environment (CPU memory stage plus data memory)
interface load_store_unit_if #(
  parameter int ADDR_W = 64
);
  // request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  // response channel
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic              resp_err;
  // data memory bus (doubleword indexed)
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [63:0]       mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_write, mem_read
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the 32 x 64-bit data memory.
// Takes one load/store at a time, sequences setup/strobe/hold cycles on the
// memory bus, does read-modify-write for sub-doubleword stores and
// extracts/extends sub-doubleword loads, then returns a response.
//
// Parameters:
//   MEM_LATENCY - cycles from the read-strobe cycle until mem_rdata is
//                 sampled (1..7)
//   ADDR_W      - request / memory address width (must match the interface)
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst_n     - synchronous active-low reset
//   bus       - load_store_unit_if.slave (request, response, memory bus)
//   dbg_state - current FSM state encoding, for observation only
//
// Optional build macro:
//   MISALIGN_CHECK_EN - requests whose address is not aligned to the access
//                       size are answered at once with resp_err=1 and no
//                       memory access. Without it resp_err is always 0 and
//                       bytes beyond the doubleword are simply dropped.
module load_store_unit #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  load_store_unit_if.slave      bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_SETUP  = 3'd1,
    RD_STROBE = 3'd2,
    RD_WAIT   = 3'd3,
    WR_SETUP  = 3'd4,
    WR_STROBE = 3'd5,
    WR_HOLD   = 3'd6,
    RESP      = 3'd7
  } state_t;

  // RD_WAIT runs MEM_LATENCY cycles; the counter reaches zero on the last one.
  localparam logic [2:0] WAIT_INIT = 3'(MEM_LATENCY - 1);

  state_t            state;
  logic [2:0]        wait_cnt;

  // latched request fields
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [2:0]        r_off;
  logic [63:0]       r_wdata;

  // registered outputs
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [63:0]       resp_rdata_q;
  logic              resp_err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [63:0]       mem_wdata_q;
  logic              mem_read_q;
  logic              mem_write_q;

  logic [63:0]       merged;
  logic [63:0]       extracted;

  // Replace (1 << size) bytes of old_dw starting at byte off with the low
  // bytes of wd. Bytes that would land past byte 7 are dropped.
  function automatic logic [63:0] merge_store(input logic [63:0] old_dw,
                                              input logic [63:0] wd,
                                              input logic [2:0]  off,
                                              input logic [1:0]  size);
    logic [63:0] res;
    int          o;
    int          n;
    res = old_dw;
    o   = int'(off);
    n   = 1 << size;
    for (int i = 0; i < 8; i++) begin
      if (i >= o && (i - o) < n) begin
        res[8*i +: 8] = wd[8*(i-o) +: 8];
      end
    end
    return res;
  endfunction

  // Shift the doubleword down to the addressed byte, keep (1 << size) bytes
  // and extend from the top kept bit. Bytes shifted in from above byte 7 are
  // zero, which is how a boundary-crossing access gets its dropped bytes.
  function automatic logic [63:0] extract_load(input logic [63:0] dw,
                                               input logic [2:0]  off,
                                               input logic [1:0]  size,
                                               input logic        sgn);
    logic [63:0] sh;
    logic [63:0] res;
    sh = dw >> {off, 3'b000};
    unique case (size)
      2'd0:    res = sgn ? {{56{sh[7]}},  sh[7:0]}  : {56'd0, sh[7:0]};
      2'd1:    res = sgn ? {{48{sh[15]}}, sh[15:0]} : {48'd0, sh[15:0]};
      2'd2:    res = sgn ? {{32{sh[31]}}, sh[31:0]} : {32'd0, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  always_comb begin
    merged    = merge_store(bus.mem_rdata, r_wdata, r_off, r_size);
    extracted = extract_load(bus.mem_rdata, r_off, r_size, r_signed);
  end

`ifdef MISALIGN_CHECK_EN
  logic [2:0] align_mask;
  logic       misaligned;

  always_comb begin
    unique case (bus.req_size)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    misaligned = |(bus.req_addr[2:0] & align_mask);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      r_write      <= 1'b0;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_off        <= '0;
      r_wdata      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // req_ready is high exactly while in IDLE, so valid alone accepts.
          if (bus.req_valid) begin
            r_write     <= bus.req_write;
            r_size      <= bus.req_size;
            r_signed    <= bus.req_signed;
            r_off       <= bus.req_addr[2:0];
            r_wdata     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            mem_addr_q  <= bus.req_addr >> 3;
`ifdef MISALIGN_CHECK_EN
            if (misaligned) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
              state        <= RESP;
            end else
`endif
            if (bus.req_write && bus.req_size == 2'd3) begin
              // full doubleword store needs no read
              mem_wdata_q <= bus.req_wdata;
              state       <= WR_SETUP;
            end else begin
              state <= RD_SETUP;
            end
          end
        end

        RD_SETUP: begin
          mem_read_q <= 1'b1;
          state      <= RD_STROBE;
        end

        RD_STROBE: begin
          mem_read_q <= 1'b0;
          wait_cnt   <= WAIT_INIT;
          state      <= RD_WAIT;
        end

        RD_WAIT: begin
          if (wait_cnt == 3'd0) begin
            if (r_write) begin
              mem_wdata_q <= merged;
              state       <= WR_SETUP;
            end else begin
              resp_rdata_q <= extracted;
              resp_valid_q <= 1'b1;
              state        <= RESP;
            end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        WR_SETUP: begin
          mem_write_q <= 1'b1;
          state       <= WR_STROBE;
        end

        WR_STROBE: begin
          mem_write_q <= 1'b0;
          state       <= WR_HOLD;
        end

        WR_HOLD: begin
          resp_rdata_q <= '0;
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end

        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: bench for load_store_unit. Provides a 32 x 64-bit data
// memory with MEM_LATENCY read latency, drives directed and random requests,
// and compares responses and memory contents with a byte-level reference
// model kept in ref_mem.
module tb_load_store_unit;

  localparam int LAT    = 1;
  localparam int ADDR_W = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [63:0] mem[32];
  logic [63:0] ref_mem[32];

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.MEM_LATENCY(LAT), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- comparison helper ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_load(input logic [63:0] dw, input int off,
                                             input int sz, input bit sg);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = '0;
    for (int b = 0; b < n; b++)
      if (off + b < 8) v[8*b +: 8] = dw[8*(off+b) +: 8];
    if (sg && n < 8 && v[8*n-1])
      for (int b = n; b < 8; b++) v[8*b +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [63:0] model_store(input logic [63:0] dw, input logic [63:0] wd,
                                              input int off, input int sz);
    logic [63:0] v;
    v = dw;
    for (int b = 0; b < (1 << sz); b++)
      if (off + b < 8) v[8*(off+b) +: 8] = wd[8*b +: 8];
    return v;
  endfunction

  // ---------------- memory model and bus monitor ----------------
  int          rd_total = 0;
  int          wr_total = 0;
  logic [63:0] last_rd_addr, last_wr_addr;
  logic [63:0] prev_addr = '0, prev_wdata = '0;
  bit          prev_strobe = 0;
  bit          hold_chk = 0, hold_wr = 0;
  logic [63:0] hold_addr, hold_wdata;
  int          rd_pipe = 0;
  logic [63:0] rd_buf;
  bit          rst_at_edge = 1;

  always @(posedge clk) rst_at_edge <= !rst_n;

  always @(negedge clk) begin
    // read data is valid only on the sampling cycle; junk otherwise
    bus.mem_rdata = {$urandom, $urandom};
    if (rd_pipe > 0) begin
      rd_pipe--;
      if (rd_pipe == 0) bus.mem_rdata = rd_buf;
    end
    if (bus.mem_read) begin
      rd_pipe = LAT;
      rd_buf  = mem[bus.mem_addr[4:0]];
      rd_total++;
      last_rd_addr = bus.mem_addr;
    end
    if (bus.mem_write) begin
      mem[bus.mem_addr[4:0]] = bus.mem_wdata;
      wr_total++;
      last_wr_addr = bus.mem_addr;
    end
    if (bus.mem_read || bus.mem_write) begin
      check("strobe_gap", 64'(prev_strobe), 64'd0);
      check("setup_addr", bus.mem_addr, prev_addr);
      if (bus.mem_write) check("setup_wdata", bus.mem_wdata, prev_wdata);
      hold_chk   = 1;
      hold_wr    = bus.mem_write;
      hold_addr  = bus.mem_addr;
      hold_wdata = bus.mem_wdata;
    end else if (hold_chk) begin
      if (!rst_at_edge) begin
        check("hold_addr", bus.mem_addr, hold_addr);
        if (hold_wr) check("hold_wdata", bus.mem_wdata, hold_wdata);
      end
      hold_chk = 0;
    end
    prev_addr   = bus.mem_addr;
    prev_wdata  = bus.mem_wdata;
    prev_strobe = bus.mem_read || bus.mem_write;
  end

  // ---------------- driver ----------------
  task automatic drive_req(input bit wr, input logic [1:0] sz, input bit sg,
                           input logic [63:0] addr, input logic [63:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
  endtask

  task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input int hold, output logic [63:0] got);
    int idx, off, exp_lat, exp_rd, exp_wr, cyc, rd0, wr0;
    bit mis, exp_err;
    logic [63:0] r0;
    idx = int'(addr[7:3]);
    off = int'(addr[2:0]);
    mis = 0;
`ifdef MISALIGN_CHECK_EN
    mis = (off % (1 << sz)) != 0;
`endif
    exp_err = mis;
    if (mis) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
      exp_q.push_back(64'd0);
    end else if (!wr) begin
      exp_lat = 4 + LAT - 1; exp_rd = 1; exp_wr = 0;
      exp_q.push_back(model_load(ref_mem[idx], off, int'(sz), sg));
    end else if (sz == 2'd3) begin
      exp_lat = 4; exp_rd = 0; exp_wr = 1;
      exp_q.push_back(64'd0);
      ref_mem[idx] = wd;
    end else begin
      exp_lat = 7 + LAT - 1; exp_rd = 1; exp_wr = 1;
      exp_q.push_back(64'd0);
      ref_mem[idx] = model_store(ref_mem[idx], wd, off, int'(sz));
    end
    rd0 = rd_total;
    wr0 = wr_total;

    @(negedge clk);
    drive_req(wr, sz, sg, addr, wd);
    cyc = 0;
    while (!bus.req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    check("req_ready_idle", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    // keep valid high with unrelated fields while busy: must be ignored
    drive_req($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
              64'($urandom_range(0, 255)), {$urandom, $urandom});
    @(negedge clk);
    cyc = 1;
    while (!bus.resp_valid && cyc < 40) begin @(negedge clk); cyc++; end
    bus.req_valid = 1'b0;
    check("latency", 64'(cyc), 64'(exp_lat));
    check("resp_err", 64'(bus.resp_err), 64'(exp_err));
    got = bus.resp_rdata;
    check("resp_rdata", got, exp_q.pop_front());
    r0 = got;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(bus.resp_valid), 64'd1);
      check("hold_rdata", bus.resp_rdata, r0);
      check("hold_busy", 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("post_valid", 64'(bus.resp_valid), 64'd0);
    check("post_ready", 64'(bus.req_ready), 64'd1);
    check("rd_strobes", 64'(rd_total - rd0), 64'(exp_rd));
    check("wr_strobes", 64'(wr_total - wr0), 64'(exp_wr));
    if (exp_rd != 0) check("rd_addr", last_rd_addr, addr >> 3);
    if (exp_wr != 0) check("wr_addr", last_wr_addr, addr >> 3);
    check("mem_word", mem[idx], ref_mem[idx]);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [63:0] got;
    logic [63:0] wd;
    int          n;

    for (int i = 0; i < 32; i++) begin
      mem[i]     = 64'd5;
      ref_mem[i] = 64'd5;
    end
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_err", 64'(bus.resp_err), 64'd0);
    check("rst_mem_read", 64'(bus.mem_read), 64'd0);
    check("rst_mem_write", 64'(bus.mem_write), 64'd0);
    check("rst_resp_rdata", bus.resp_rdata, 64'd0);
    check("rst_mem_addr", bus.mem_addr, 64'd0);
    check("rst_mem_wdata", bus.mem_wdata, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // doubleword load of the preset value
    do_req(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 0, got);
    check("plan_ld_dw", got, 64'h5);

    // byte store into word 3 (read-modify-write)
    do_req(1'b1, 2'd0, 1'b0, 64'h19, 64'hAB, 0, got);
    check("plan_st_b_word", mem[3], 64'h000000000000AB05);

    // signed and unsigned byte loads of the stored byte
    do_req(1'b0, 2'd0, 1'b1, 64'h19, 64'd0, 0, got);
    check("plan_ld_sb", got, 64'hFFFFFFFFFFFFFFAB);
    do_req(1'b0, 2'd0, 1'b0, 64'h19, 64'd0, 0, got);
    check("plan_ld_ub", got, 64'h00000000000000AB);

    // doubleword store with consumer backpressure
    do_req(1'b1, 2'd3, 1'b0, 64'h40, 64'h1122334455667788, 3, got);
    check("plan_st_dw_word", mem[8], 64'h1122334455667788);

    // reset while the write strobe is high
    wd = {$urandom, $urandom};
    @(negedge clk);
    drive_req(1'b1, 2'd3, 1'b0, 64'h60, wd);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.mem_write && n < 20) begin @(negedge clk); n++; end
    check("rst_mid_strobe", 64'(bus.mem_write), 64'd1);
    // the strobe was high for a whole cycle, so the memory took the write
    ref_mem[12] = wd;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_write", 64'(bus.mem_write), 64'd0);
    check("rst_mid_ready", 64'(bus.req_ready), 64'd1);
    check("rst_mid_valid", 64'(bus.resp_valid), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_no_resp", 64'(bus.resp_valid), 64'd0);
    do_req(1'b0, 2'd3, 1'b0, 64'h60, 64'd0, 0, got);
    check("rst_mid_value", got, wd);

    // half load at an odd address
    do_req(1'b0, 2'd1, 1'b0, 64'h11, 64'd0, 0, got);

    // doubleword-boundary crossing: word load at byte offset 6 keeps 2 bytes
    do_req(1'b1, 2'd3, 1'b0, 64'h28, 64'h8899AABBCCDDEEFF, 0, got);
    do_req(1'b0, 2'd2, 1'b1, 64'h2E, 64'd0, 0, got);

    // random traffic
    for (int t = 0; t < 60; t++) begin
      do_req($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
             64'($urandom_range(0, 255)), {$urandom, $urandom},
             $urandom_range(0, 2), got);
    end

    // final memory sweep
    for (int i = 0; i < 32; i++) check("sweep", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store request at a time from the CPU memory stage.
- Sequences address, data and read/write strobes into the 32 x 64-bit data memory.
- Performs read-modify-write for sub-doubleword stores and extracts/extends sub-doubleword loads.
- Returns load data or a store acknowledge on a valid/ready response channel.

Parameters:
- MEM_LATENCY, 1: cycles from the read-strobe cycle until mem_rdata is sampled (1..7).
- ADDR_W, 64: width of request and memory address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = doubleword.
- req_signed  in  1  load sign-extends when 1, zero-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  64  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  64  load result; 0 for stores.
- resp_err  out  1  access error; tied 0 unless MISALIGN_CHECK_EN.
- mem_addr  out  ADDR_W  doubleword index = req_addr >> 3.
- mem_wdata  out  64  doubleword to write.
- mem_write  out  1  write strobe, single-cycle pulse.
- mem_read  out  1  read strobe, single-cycle pulse.
- mem_rdata  in  64  doubleword read data.

Behaviour:
- Reset: applied while rst_n low at clk edge. Returns to IDLE and aborts any in-flight access. Outputs after reset: req_ready=1; resp_valid, resp_err, mem_read, mem_write = 0; resp_rdata, mem_addr, mem_wdata = 0.
- Reset mid-operation: a strobe asserted in the reset cycle is deasserted the next cycle; no response is produced.
- Accept: on req_valid && req_ready, latch all req_* fields. The request cycle is cycle 0.
- FSM states: IDLE, RD_SETUP, RD_STROBE, RD_WAIT, WR_SETUP, WR_STROBE, WR_HOLD, RESP.
- IDLE transitions: a load or a sub-doubleword store goes to RD_SETUP; a doubleword store goes to WR_SETUP.
- RD_SETUP: drive mem_addr.
- RD_STROBE: mem_read=1 for exactly one cycle, mem_addr held.
- RD_WAIT: count MEM_LATENCY cycles, then capture mem_rdata on the last wait cycle.
  - Load: go to RESP.
  - Store: merge the low (1 << req_size) bytes of req_wdata into the captured doubleword at byte offset req_addr[2:0], then go to WR_SETUP.
- WR_SETUP: drive mem_addr and mem_wdata.
- WR_STROBE: mem_write=1 for one cycle.
- WR_HOLD: addr/data held one more cycle, strobe low; then go to RESP.
- Strobe rule: mem_addr/mem_wdata are stable from the setup cycle through one cycle after the strobe. Strobes are never high in consecutive cycles, so every access is a fresh 0->1 edge.
- Load extract: shift the captured doubleword right by 8*offset and keep (1 << req_size) bytes. Sign-extend the top kept bit if req_signed, else zero-extend.
- Bytes crossing a doubleword boundary are dropped (aligned-down behaviour) unless the optional feature is compiled in.
- RESP: resp_valid=1 and resp_rdata stable until resp_ready. IDLE follows the handshake cycle, and req_ready rises the same cycle IDLE is entered.
- Latency to first resp_valid (MEM_LATENCY=1): load = cycle 4; doubleword store = cycle 4; sub-doubleword store = cycle 7.
- Latency scales by +(MEM_LATENCY-1) for any access that reads.
- Simultaneous events: req_valid in any non-IDLE state is ignored (req_ready=0). resp_ready without resp_valid has no effect.

Optional Feature:
- MISALIGN_CHECK_EN defined:
  - An accepted request with req_addr not aligned to (1 << req_size) bytes skips all memory states.
  - Goes directly to RESP with resp_err=1 and resp_rdata=0, at cycle 1.
  - No strobe is issued.
- Not defined: resp_err is constantly 0 and the offset is used as described in Behaviour.

Test Plan:
- Memory preset to 5 in every doubleword; load size 3 at addr 0x10 -> mem_read pulses once with mem_addr=2; resp_rdata=0x0000000000000005 at cycle 4.
- Store byte 0xAB at addr 0x19 -> read then write of index 3; the word becomes 0x000000000000AB05; resp_rdata=0 at cycle 7.
- After the previous step, signed byte load at 0x19 -> resp_rdata=0xFFFFFFFFFFFFFFAB. Unsigned -> 0x00000000000000AB.
- Store doubleword 0x1122334455667788 at 0x40, hold resp_ready=0 for 3 cycles -> no mem_read; resp_valid held 3 extra cycles with data stable; req_ready stays 0 until the handshake.
- Assert rst_n=0 during WR_STROBE of a store -> next cycle IDLE, mem_write=0, req_ready=1, no resp_valid. A following load returns the pre-store value if the strobe never completed the edge, otherwise the new value.
- With MISALIGN_CHECK_EN, half load at 0x11 -> resp_valid at cycle 1, resp_err=1, resp_rdata=0, zero strobes. Without the macro -> normal load, resp_err=0.
